keypad_matrix_emulator: RTL and testbench

//  Synthesizable model of a 4x4 key matrix: the far end of the keypad scanner's column/row interface.

---
 rtl/keypad_pkg.sv | 28 ++
 rtl/keypad_matrix_emulator_if.sv | 14 +
 rtl/keypad_bounce_gen.sv | 46 ++++
 rtl/keypad_matrix_emulator.sv | 122 ++++++++++++
 tb/tb_keypad_matrix_emulator.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad matrix: geometry, key-code fields and emulator states.
package keypad_pkg;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;
  localparam int KEY_W    = 4;
  localparam int ROW_MSB  = 3;
  localparam int ROW_LSB  = 2;
  localparam int COL_MSB  = 1;
  localparam int COL_LSB  = 0;

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_IN,
    HELD,
    BOUNCE_OUT,
    GAP
  } kp_state_e;

  function automatic logic [1:0] key_row(input logic [KEY_W-1:0] code);
    return code[ROW_MSB:ROW_LSB];
  endfunction

  function automatic logic [1:0] key_col(input logic [KEY_W-1:0] code);
    return code[COL_MSB:COL_LSB];
  endfunction

endpackage

// File: rtl/keypad_matrix_emulator_if.sv
// Command port of the keypad emulator: press a key code for a given hold time.
interface keypad_matrix_emulator_if
  import keypad_pkg::*;
#(
  parameter int HOLD_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [KEY_W-1:0]  cmd_key;
  logic [HOLD_W-1:0] cmd_hold;

  modport master (output cmd_valid, output cmd_key, output cmd_hold, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_key, input cmd_hold, output cmd_ready);
endinterface

// File: rtl/keypad_bounce_gen.sv
// Paces a contact-bounce burst: after start, pulses toggle every BOUNCE_PERIOD cycles
// until BOUNCE_EDGES toggles exist in total (the caller performs the first one on start).
module keypad_bounce_gen #(
  parameter int BOUNCE_PERIOD = 8,
  parameter int BOUNCE_EDGES  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic toggle,
  output logic done
);

  localparam int PW = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;
  localparam int EW = $clog2(BOUNCE_EDGES + 1);
  localparam logic [PW-1:0] PER_LAST  = PW'(BOUNCE_PERIOD - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(BOUNCE_EDGES - 1);

  logic          active;
  logic [PW-1:0] period_cnt;
  logic [EW-1:0] edge_cnt;

  assign toggle = active & (period_cnt == PER_LAST);
  assign done   = toggle & (edge_cnt == EDGE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active     <= 1'b0;
      period_cnt <= '0;
      edge_cnt   <= '0;
    end else if (start) begin
      active     <= 1'b1;
      period_cnt <= '0;
      edge_cnt   <= EW'(1);
    end else if (active) begin
      if (toggle) begin
        period_cnt <= '0;
        edge_cnt   <= edge_cnt + 1'b1;
        if (done) active <= 1'b0;
      end else begin
        period_cnt <= period_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_matrix_emulator.sv
// Far end of a 4x4 keypad scan interface: presses a commanded key with contact bounce,
// holds it, releases it with bounce, then enforces an open-contact gap.
module keypad_matrix_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_W        = 16,
  parameter int BOUNCE_PERIOD = 8,
  parameter int BOUNCE_EDGES  = 3,
  parameter int GAP_CYCLES    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  keypad_matrix_emulator_if.slave cmd,
  input  logic [KEY_COLS-1:0] keycolumn,
  output logic [KEY_ROWS-1:0] keyrow,
  output logic                busy,
  output logic                contact
);

  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0]     GAP_LOAD = GW'(GAP_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam bit                CHATTER  = (BOUNCE_EDGES > 1);

  kp_state_e         state;
  logic [KEY_W-1:0]  key;
  logic [HOLD_W-1:0] hold_cnt;
  logic [GW-1:0]     gap_cnt;
  logic              ready;
  logic              take;
  logic              release_now;
  logic              bounce_start;
  logic              bounce_toggle;
  logic              bounce_done;

  assign cmd.cmd_ready = ready;
  assign take          = cmd.cmd_valid & ready;
  assign release_now   = (state == HELD) && (hold_cnt == HOLD_ONE);
  // One pacing engine serves both bursts; press and release never overlap.
  assign bounce_start  = CHATTER & (take | release_now);

  keypad_bounce_gen #(
    .BOUNCE_PERIOD (BOUNCE_PERIOD),
    .BOUNCE_EDGES  (BOUNCE_EDGES)
  ) u_bounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (bounce_start),
    .toggle (bounce_toggle),
    .done   (bounce_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      contact  <= 1'b0;
      key      <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      ready    <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            key      <= cmd.cmd_key;
            hold_cnt <= (cmd.cmd_hold == '0) ? HOLD_ONE : cmd.cmd_hold;
            contact  <= 1'b1;
            ready    <= 1'b0;
            busy     <= 1'b1;
            state    <= CHATTER ? BOUNCE_IN : HELD;
          end
        end
        BOUNCE_IN: begin
          if (bounce_toggle) begin
            contact <= ~contact;
            if (bounce_done) state <= HELD;
          end
        end
        HELD: begin
          if (release_now) begin
            contact <= 1'b0;
            if (CHATTER) begin
              state <= BOUNCE_OUT;
            end else begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        BOUNCE_OUT: begin
          if (bounce_toggle) begin
            contact <= ~contact;
            if (bounce_done) begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Row sense follows the column drive combinationally; only the latched key's column matters.
  always_comb begin
    keyrow = '0;
    keyrow[key_row(key)] = contact & keycolumn[key_col(key)];
  end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Bench for keypad_matrix_emulator: a bouncing instance and a clean (single-edge) instance
// checked every cycle against a closed-form timing model of the press/hold/release/gap sequence.
module tb_keypad_matrix_emulator;
  import keypad_pkg::*;

  localparam int HOLD_W = 16;
  localparam int P0 = 8, B0 = 3, G0 = 16;
  localparam int P1 = 8, B1 = 1, G1 = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]        keycolumn;
  logic              vld [2];
  logic [3:0]        key [2];
  logic [HOLD_W-1:0] hold [2];
  logic              rdy [2];
  logic [3:0]        row_o [2];
  logic              busy_o [2];
  logic              contact_o [2];

  keypad_matrix_emulator_if #(.HOLD_W(HOLD_W)) c0 ();
  keypad_matrix_emulator_if #(.HOLD_W(HOLD_W)) c1 ();

  assign c0.cmd_valid = vld[0];
  assign c0.cmd_key   = key[0];
  assign c0.cmd_hold  = hold[0];
  assign rdy[0]       = c0.cmd_ready;
  assign c1.cmd_valid = vld[1];
  assign c1.cmd_key   = key[1];
  assign c1.cmd_hold  = hold[1];
  assign rdy[1]       = c1.cmd_ready;

  keypad_matrix_emulator #(.HOLD_W(HOLD_W), .BOUNCE_PERIOD(P0), .BOUNCE_EDGES(B0), .GAP_CYCLES(G0)) dut0 (
    .clk(clk), .rst_n(rst_n), .cmd(c0), .keycolumn(keycolumn),
    .keyrow(row_o[0]), .busy(busy_o[0]), .contact(contact_o[0]));

  keypad_matrix_emulator #(.HOLD_W(HOLD_W), .BOUNCE_PERIOD(P1), .BOUNCE_EDGES(B1), .GAP_CYCLES(G1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd(c1), .keycolumn(keycolumn),
    .keyrow(row_o[1]), .busy(busy_o[1]), .contact(contact_o[1]));

  int n_checks = 0;
  int n_errors = 0;

  bit         m_idle [2];
  int         m_k [2];
  logic [3:0] m_key [2];
  int         m_hold [2];
  bit         acc [2];
  bit         rnd_en;
  int         col_mode;
  logic [3:0] col_const;
  int         cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int per(input int i);
    return (i == 0) ? P0 : P1;
  endfunction
  function automatic int edg(input int i);
    return (i == 0) ? B0 : B1;
  endfunction
  function automatic int gapc(input int i);
    return (i == 0) ? G0 : G1;
  endfunction

  function automatic int total(input int i, input int h);
    return 2 * (edg(i) - 1) * per(i) + h + gapc(i) + 1;
  endfunction

  // Contact level k cycles after the accepting edge: press burst, stable hold, release burst, open.
  function automatic bit contact_model(input int i, input int k, input int h);
    int bi;
    int r;
    bi = (edg(i) - 1) * per(i);
    if (k < bi) return ((k / per(i)) % 2) == 0;
    if (k < bi + h) return 1'b1;
    r = k - bi - h;
    if (r < bi) return ((r / per(i)) % 2) == 1;
    return 1'b0;
  endfunction

  task automatic step();
    bit         c;
    logic [3:0] er;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      acc[i] = 1'b0;
      if (m_idle[i]) begin
        if (vld[i]) begin
          m_idle[i] = 1'b0;
          m_k[i]    = 0;
          m_key[i]  = key[i];
          m_hold[i] = (hold[i] == '0) ? 1 : int'(hold[i]);
          acc[i]    = 1'b1;
        end
      end else begin
        m_k[i]++;
        if (m_k[i] >= total(i, m_hold[i])) m_idle[i] = 1'b1;
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      c  = m_idle[i] ? 1'b0 : contact_model(i, m_k[i], m_hold[i]);
      er = (c && keycolumn[m_key[i][1:0]]) ? (4'b0001 << m_key[i][3:2]) : 4'b0000;
      chk($sformatf("contact%0d", i), 32'(contact_o[i]), 32'(c));
      chk($sformatf("keyrow%0d", i), 32'(row_o[i]), 32'(er));
      chk($sformatf("ready%0d", i), 32'(rdy[i]), 32'(m_idle[i]));
      chk($sformatf("busy%0d", i), 32'(busy_o[i]), 32'(!m_idle[i]));
    end
    case (col_mode)
      0:       keycolumn = 4'($urandom);
      1:       keycolumn = 4'b0001 << ((cyc / 4) % 4);
      default: keycolumn = col_const;
    endcase
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) vld[i] = 1'b0;
      if (rnd_en && !vld[i] && $urandom_range(0, 3) == 0) begin
        vld[i]  = 1'b1;
        key[i]  = 4'($urandom);
        hold[i] = ($urandom_range(0, 7) == 0) ? '0 : HOLD_W'($urandom_range(1, 40));
      end
    end
  endtask

  task automatic issue(input int i, input logic [3:0] k, input int h);
    vld[i]  = 1'b1;
    key[i]  = k;
    hold[i] = HOLD_W'(h);
    acc[i]  = 1'b0;
  endtask

  task automatic wait_acc(input int i);
    for (int n = 0; n < 3000 && !acc[i]; n++) step();
    chk($sformatf("accept%0d", i), 32'(acc[i]), 32'd1);
  endtask

  task automatic measure(input int i, input logic [3:0] pat, output int nb, output int nr);
    nb = 0;
    nr = 0;
    while (busy_o[i] && nb < 3000) begin
      nb++;
      if (row_o[i] == pat) nr++;
      step();
    end
  endtask

  task automatic set_col(input logic [3:0] v);
    col_mode  = 2;
    col_const = v;
    keycolumn = v;
  endtask

  initial begin
    int nb;
    int nr;
    int n;
    rnd_en    = 1'b0;
    vld       = '{1'b0, 1'b0};
    key       = '{4'h0, 4'h0};
    hold      = '{'0, '0};
    m_idle    = '{1'b1, 1'b1};
    m_k       = '{0, 0};
    m_key     = '{4'h0, 4'h0};
    m_hold    = '{1, 1};
    acc       = '{1'b0, 1'b0};
    set_col(4'hF);

    #1 rst_n = 1'b0;
    #6;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_ready%0d", i), 32'(rdy[i]), 32'd1);
      chk($sformatf("rst_busy%0d", i), 32'(busy_o[i]), 32'd0);
      chk($sformatf("rst_contact%0d", i), 32'(contact_o[i]), 32'd0);
      chk($sformatf("rst_keyrow%0d", i), 32'(row_o[i]), 32'd0);
    end
    #5 rst_n = 1'b1;
    step();

    // Clean press: key row1/col2 seen on keyrow[1] for exactly the hold time.
    set_col(4'b0100);
    issue(1, 4'b0110, 50);
    wait_acc(1);
    measure(1, 4'b0010, nb, nr);
    chk("clean_busy", 32'(nb), 32'd67);
    chk("clean_rows", 32'(nr), 32'd50);

    // Column scan with the bottom-right key.
    col_mode = 1;
    issue(0, 4'b1111, 60);
    wait_acc(0);
    measure(0, 4'b1000, nb, nr);
    chk("scan_busy", 32'(nb), 32'd109);

    // Default bounce: closed 8 + 20 stable + 8 during release burst.
    set_col(4'b0001);
    issue(0, 4'b0000, 20);
    wait_acc(0);
    measure(0, 4'b0001, nb, nr);
    chk("bounce_busy", 32'(nb), 32'd69);
    chk("bounce_rows", 32'(nr), 32'd36);

    // Back-pressure: second command waits for the first idle cycle.
    issue(0, 4'h5, 10);
    wait_acc(0);
    issue(0, 4'hA, 5);
    n = 0;
    while (!acc[0] && n < 3000) begin
      step();
      n++;
    end
    chk("bp_accept_dist", 32'(n), 32'd60);
    measure(0, 4'b0000, nb, nr);
    chk("bp_second_busy", 32'(nb), 32'd54);

    // hold=0 behaves as hold=1; key row2/col1.
    set_col(4'b0010);
    issue(1, 4'b1001, 0);
    wait_acc(1);
    measure(1, 4'b0100, nb, nr);
    chk("hold0_busy1", 32'(nb), 32'd18);
    chk("hold0_rows1", 32'(nr), 32'd1);
    issue(0, 4'b1001, 0);
    wait_acc(0);
    measure(0, 4'b0100, nb, nr);
    chk("hold0_busy0", 32'(nb), 32'd50);
    chk("hold0_rows0", 32'(nr), 32'd17);

    // Asynchronous reset ten cycles into a long hold.
    set_col(4'b0001);
    issue(0, 4'b0100, 100);
    wait_acc(0);
    for (int k = 0; k < 200 && m_k[0] < 26; k++) step();
    chk("pre_rst_contact", 32'(contact_o[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_contact", 32'(contact_o[0]), 32'd0);
    chk("mid_rst_keyrow", 32'(row_o[0]), 32'd0);
    chk("mid_rst_ready", 32'(rdy[0]), 32'd1);
    vld    = '{1'b0, 1'b0};
    m_idle = '{1'b1, 1'b1};
    @(posedge clk);
    #1;
    chk("in_rst_contact", 32'(contact_o[0]), 32'd0);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("post_rst_ready", 32'(rdy[0]), 32'd1);

    // Randomised commands and arbitrary column patterns.
    rnd_en   = 1'b1;
    col_mode = 0;
    repeat (2500) step();
    rnd_en = 1'b0;
    for (int k = 0; k < 3000 && !(m_idle[0] && m_idle[1] && !vld[0] && !vld[1]); k++) step();
    chk("drain_idle", 32'(m_idle[0] && m_idle[1]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
